inta_sequencer: RTL and testbench

INTA_SEQUENCER -- requirements
Module: inta_sequencer

---
 rtl/inta_sequencer.sv | 124 ++++++++++++
 tb/tb_inta_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse acknowledge, drives the vector, keeps the ISR.
// Optional build macro AUTO_EOI_EN clears the serviced ISR bit automatically after the acknowledge ends.
module inta_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic [2:0] last_serviced
);

  typedef enum logic [1:0] {IDLE, REQ, ACK1, ACK2} state_t;

  state_t     state;
  logic       inta_prev;
  logic [2:0] frozen_level;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] req_level;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] isr_next;

  assign inta_fall = !inta_n && inta_prev;
  assign inta_rise = inta_n && !inta_prev;

  always_comb begin
    req_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) req_level = 3'(i);
    end
  end

  assign set_mask = (state == REQ && inta_fall && interrupt != 8'h00) ? (8'h01 << req_level) : 8'h00;

`ifdef AUTO_EOI_EN
  logic auto_pending;
  logic serviced_real;

  // Remember whether the current acknowledge was real, then clear its bit one cycle after IDLE is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_pending  <= 1'b0;
      serviced_real <= 1'b0;
    end else begin
      if (state == REQ && inta_fall) serviced_real <= (interrupt != 8'h00);
      auto_pending <= (state == ACK2 && inta_rise && serviced_real);
    end
  end
`endif

  always_comb begin
    clr_mask = 8'h00;
    if (eoi_valid) begin
      if (eoi_specific) clr_mask = 8'h01 << eoi_level;
      else              clr_mask = in_service_register & ~(in_service_register - 8'd1);
    end
`ifdef AUTO_EOI_EN
    if (auto_pending) clr_mask = clr_mask | (8'h01 << frozen_level);
`endif
    // Set is applied after clear so a same-cycle set of the same bit wins.
    isr_next = (in_service_register & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      int_out             <= 1'b0;
      in_service_register <= 8'h00;
      data_out            <= 8'h00;
      data_out_en         <= 1'b0;
      last_serviced       <= 3'd7;
      inta_prev           <= 1'b1;
      frozen_level        <= 3'd7;
    end else begin
      inta_prev           <= inta_n;
      in_service_register <= isr_next;
      case (state)
        IDLE: begin
          if (interrupt != 8'h00) begin
            state   <= REQ;
            int_out <= 1'b1;
          end
        end
        REQ: begin
          if (inta_fall) begin
            state   <= ACK1;
            int_out <= 1'b0;
            // A request that vanished before the acknowledge is spurious and reports level 7.
            if (interrupt != 8'h00) begin
              frozen_level  <= req_level;
              last_serviced <= req_level;
            end else begin
              frozen_level  <= 3'd7;
            end
          end
        end
        ACK1: begin
          if (inta_fall) begin
            state       <= ACK2;
            data_out    <= {vector_base, frozen_level};
            data_out_en <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state       <= IDLE;
            data_out    <= 8'h00;
            data_out_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed scenarios plus randomized acknowledge/EOI traffic
// compared against a bit-array ISR model.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] interrupt = 8'h00;
  logic       inta_n = 1'b1;
  logic [4:0] vector_base = 5'b01000;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [2:0] last_serviced;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_isr = 8'h00;
  logic [2:0] m_last = 3'd7;

  inta_sequencer dut (
    .clk(clk),
    .reset(reset),
    .interrupt(interrupt),
    .inta_n(inta_n),
    .vector_base(vector_base),
    .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific),
    .eoi_level(eoi_level),
    .int_out(int_out),
    .in_service_register(in_service_register),
    .data_out(data_out),
    .data_out_en(data_out_en),
    .last_serviced(last_serviced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ISR rules: specific clears the named bit, non-specific clears the highest priority (lowest index) set bit.
  task automatic model_eoi(input logic spec, input logic [2:0] lvl);
    if (spec) m_isr[lvl] = 1'b0;
    else begin
      for (int i = 0; i < 8; i++) begin
        if (m_isr[i]) begin
          m_isr[i] = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #2;
    check({tag, "_int"}, {7'b0, int_out}, 8'h00);
    check({tag, "_isr"}, in_service_register, 8'h00);
    check({tag, "_dout"}, data_out, 8'h00);
    check({tag, "_den"}, {7'b0, data_out_en}, 8'h00);
    check({tag, "_last"}, {5'b0, last_serviced}, 8'h07);
    tick();
    reset = 1'b0;
    m_isr = 8'h00;
    m_last = 3'd7;
  endtask

  task automatic do_eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_specific = spec;
    eoi_level = lvl;
    tick();
    eoi_valid = 1'b0;
    model_eoi(spec, lvl);
    check("eoi_isr", in_service_register, m_isr);
  endtask

  task automatic run_seq(input logic [2:0] lvl, input bit spurious, input bit eoi_at_ack,
                         input logic eoi_spec, input logic [2:0] eoi_lvl);
    logic [2:0] exp_level;
    interrupt = 8'h01 << lvl;
    tick();
    check("int_raise", {7'b0, int_out}, 8'h01);
    if (spurious) interrupt = 8'h00;
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("int_hold", {7'b0, int_out}, 8'h01);
    end
    inta_n = 1'b0;
    if (eoi_at_ack) begin
      eoi_valid = 1'b1;
      eoi_specific = eoi_spec;
      eoi_level = eoi_lvl;
    end
    tick();
    eoi_valid = 1'b0;
    if (eoi_at_ack) model_eoi(eoi_spec, eoi_lvl);
    if (!spurious) begin
      m_isr[lvl] = 1'b1;
      m_last = lvl;
    end
    exp_level = spurious ? 3'd7 : lvl;
    check("ack1_int", {7'b0, int_out}, 8'h00);
    check("ack1_isr", in_service_register, m_isr);
    check("ack1_last", {5'b0, last_serviced}, {5'b0, m_last});
    check("ack1_den", {7'b0, data_out_en}, 8'h00);
    interrupt = 8'h00;
    inta_n = 1'b1;
    tick();
    check("gap_den", {7'b0, data_out_en}, 8'h00);
    check("gap_dout", data_out, 8'h00);
    inta_n = 1'b0;
    tick();
    check("ack2_dout", data_out, {vector_base, exp_level});
    check("ack2_den", {7'b0, data_out_en}, 8'h01);
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("ack2_hold", {7'b0, data_out_en}, 8'h01);
    end
    inta_n = 1'b1;
    tick();
    check("end_den", {7'b0, data_out_en}, 8'h00);
    check("end_dout", data_out, 8'h00);
    tick();
`ifdef AUTO_EOI_EN
    if (!spurious) m_isr[lvl] = 1'b0;
`endif
    check("end_isr", in_service_register, m_isr);
    check("end_int", {7'b0, int_out}, 8'h00);
  endtask

  initial begin
    logic [2:0] lvl;
    apply_reset("reset0");

    // Basic acknowledge: level 3 on base 01000 gives vector 8'h43.
    vector_base = 5'b01000;
    run_seq(3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
    check("vec_last3", {5'b0, last_serviced}, 8'h03);

    // Spurious request: level 0 drops before the acknowledge.
    run_seq(3'd0, 1'b1, 1'b0, 1'b0, 3'd0);

    // EOI ordering from ISR = 8'h24.
    apply_reset("reset1");
    run_seq(3'd2, 1'b0, 1'b0, 1'b0, 3'd0);
    run_seq(3'd5, 1'b0, 1'b0, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);
    do_eoi(1'b1, 3'd5);
    do_eoi(1'b0, 3'd0);

    // Same-cycle specific EOI and set of level 2: set wins.
    run_seq(3'd2, 1'b0, 1'b1, 1'b1, 3'd2);
    check("setwins_bit2", {7'b0, in_service_register[2]}, 8'h01);

    // Falling edges in IDLE are ignored.
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    check("idle_int", {7'b0, int_out}, 8'h00);
    check("idle_den", {7'b0, data_out_en}, 8'h00);

    // Reset while in ACK1 with inta_n low.
    interrupt = 8'h10;
    tick();
    inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    #3;
    apply_reset("reset_ack1");
    tick();
    check("post_rst_int", {7'b0, int_out}, 8'h00);
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    tick();
    check("post_rst_den", {7'b0, data_out_en}, 8'h00);
    check("post_rst_dout", data_out, 8'h00);
    check("post_rst_isr", in_service_register, 8'h00);
    check("post_rst_last", {5'b0, last_serviced}, 8'h07);
    inta_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      vector_base = 5'($urandom);
      lvl = 3'($urandom);
      if ($urandom_range(0, 9) < 7)
        run_seq(lvl, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom), 3'($urandom));
      else
        do_eoi(1'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
